fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the instruction cache: owns the PC, drives the cache word address and captures the returned word every cycle it has room.
- Buffers fetched words with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Handles control-flow redirects from execute by flushing the FIFO and restarting at the target PC.

Parameters:
- RESET_PC, 32'h0000_0000, byte PC loaded on reset; bits [1:0] are ignored.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- address_o  out  29  cache word address = pc_r[30:2]; purely registered.
- read_data_i  in  32  cache read word; combinational response to address_o in the same cycle.
- halt_i  in  1  suppresses fetch while high; FIFO contents stay and can still drain.
- redirect_i  in  1  flush and restart request.
- redirect_pc_i  in  32  target byte PC; bits [1:0] are ignored.
- instr_valid_o  out  1  head entry is valid.
- instr_ready_i  in  1  decode accepts the head entry.
- instr_o  out  32  head instruction word.
- instr_pc_o  out  32  byte PC of the head word.

Behaviour:
- Reset (async assert, sync release):
  - pc_r = {RESET_PC[31:2],2'b00}.
  - FIFO empty; read/write pointers and count = 0.
  - instr_valid_o = 0; instr_o = 0; instr_pc_o = 0 while empty.
- Pop: pop = instr_valid_o & instr_ready_i.
- Fetch condition: fetch = ~halt_i & ~redirect_i & (count < DEPTH | pop).
  - A full FIFO that pops in the same cycle fetches in that cycle; there is no bubble at full.
- On fetch at the edge:
  - read_data_i and pc_r are written into the FIFO.
  - pc_r <= pc_r + 4, 32-bit add, wraps 0xFFFF_FFFC -> 0x0000_0000.
- address_o is always pc_r[30:2], even when not fetching. Bit 31 is dropped because the cache space is 2^29 words.
- instr_valid_o = (count != 0) & ~redirect_i. Masking by redirect_i means no handshake can complete in a redirect cycle.
- instr_o / instr_pc_o come from the head entry; they are don't-care when invalid but must be stable while valid and not ready.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointer width is log2(DEPTH)+1 and wraps naturally.
- Redirect (highest priority over fetch, pop and halt), at the edge:
  - FIFO is flushed (pointers and count = 0).
  - pc_r <= {redirect_pc_i[31:2],2'b00}.
  - Next cycle: fetch of the target (if halt_i is low). The cycle after: instr_valid_o = 1.
  - Redirect-to-valid latency is 2 cycles.
  - Back-to-back redirects: the last one wins.
- Halt: pc_r and the FIFO are held except for pops. Deasserting halt_i resumes fetch in the same cycle.
- Reset mid-operation discards all state immediately; outputs follow the reset values asynchronously.
- No state machine beyond FIFO occupancy; the block is fully pipelined at 1 word/cycle in steady state.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_cnt_o (32) and output flush_cnt_o (32), both reset to 0.
  - fetch_cnt_o increments on every fetch.
  - flush_cnt_o increments by the number of valid entries discarded by each redirect.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset fill:
  - Setup: RESET_PC=0; cache words 0..3 = 0x00000093, 0x10000113, 0x00a00193, 0x00900213; instr_ready_i=1.
  - Expected: valid from cycle 1 after reset release; instr_o sequence 0x00000093, 0x10000113, 0x00a00193, 0x00900213 with instr_pc_o 0, 4, 8, 12.
  - Expected: address_o 0, 1, 2, 3.
- Backpressure/full:
  - Stimulus: instr_ready_i=0 for 10 cycles after reset.
  - Expected: exactly 4 entries captured and address_o stays at 4; the head stays 0x00000093/PC 0.
  - Then: ready=1 with a full FIFO fetches word 4 in the same cycle.
- Redirect:
  - Stimulus: with 3 entries queued, pulse redirect_i with redirect_pc_i=0x000000A3.
  - Expected: valid=0 that cycle; address_o=40 the next cycle; valid with instr_pc_o=0xA0 two cycles after the pulse.
  - Expected: old entries are never delivered.
- Redirect + pop same cycle: ready=1 with redirect_i=1 -> no handshake, and the FIFO is empty after the edge.
- Halt:
  - Stimulus: assert halt_i for 5 cycles with ready=1.
  - Expected: queued entries drain and address_o is frozen; on release, fetch resumes at the frozen address with no skip or duplicate.
- PC wrap and async reset:
  - Stimulus: redirect to 0xFFFFFFFC.
  - Expected: the following fetch PC is 0x00000000.
  - Stimulus: drop rst_ni mid-cycle.
  - Expected: instr_valid_o falls immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the cache word address and queues
// fetched words with their PCs for decode. Optional counters under FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [28:0] address_o,
  input  logic [31:0] read_data_i,
  input  logic        halt_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

  logic [31:0]   pc_r;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];

  logic empty;
  logic full;
  logic pop;
  logic fetch;

  // Decode handshake: an entry transfers on a rising edge where instr_valid_o
  // and instr_ready_i are both high; once valid is raised the head entry holds
  // until that transfer or until a redirect flushes it.
  assign empty         = (count == '0);
  assign full          = (count == DEPTH_C);
  assign instr_valid_o = ~empty & ~redirect_i;
  assign pop           = instr_valid_o & instr_ready_i;
  // A pop frees a slot in the same cycle, so a full FIFO keeps fetching.
  assign fetch         = ~halt_i & ~redirect_i & (~full | pop);

  assign address_o  = pc_r[30:2];
  assign instr_o    = empty ? 32'h0 : word_q[rd_ptr[AW-1:0]];
  assign instr_pc_o = empty ? 32'h0 : pc_q[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_r   <= {RESET_PC[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_i) begin
      pc_r   <= {redirect_pc_i[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fetch) begin
        pc_r   <= pc_r + 32'd4;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({fetch, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only observable through count.
  always_ff @(posedge clk_i) begin
    if (fetch) begin
      word_q[wr_ptr[AW-1:0]] <= read_data_i;
      pc_q[wr_ptr[AW-1:0]]   <= pc_r;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_cnt_o <= 32'h0;
      flush_cnt_o <= 32'h0;
    end else begin
      if (fetch) begin
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
      end
      if (redirect_i) begin
        flush_cnt_o <= flush_cnt_o + 32'(count);
      end
    end
  end
`else
`endif

  logic unused_bits;
  assign unused_bits = ^redirect_pc_i[1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: combinational cache model, one task per scenario.
module tb_fetch_unit;

  logic        clk;
  logic        rst_ni;
  logic [28:0] address_o;
  logic [31:0] read_data_i;
  logic        halt_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  int n_vec;
  int n_err;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .address_o     (address_o),
    .read_data_i   (read_data_i),
    .halt_i        (halt_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o   (fetch_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] cache_word(input logic [28:0] a);
    case (a)
      29'd0:   cache_word = 32'h0000_0093;
      29'd1:   cache_word = 32'h1000_0113;
      29'd2:   cache_word = 32'h00a0_0193;
      29'd3:   cache_word = 32'h0090_0213;
      default: cache_word = 32'h5A00_0000 ^ {3'b000, a};
    endcase
  endfunction

  always_comb read_data_i = cache_word(address_o);

  // driver tasks
  task automatic do_reset(input logic ready);
    rst_ni        = 1'b0;
    halt_i        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = ready;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // scenarios
  task automatic test_reset();
    rst_ni        = 1'b0;
    halt_i        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (instr_valid_o !== 1'b0 || instr_o !== 32'h0 || instr_pc_o !== 32'h0 || address_o !== 29'h0) begin
      n_err++;
      $display("FAIL reset_values: valid=%b instr=%h pc=%h addr=%h, want 0/0/0/0",
               instr_valid_o, instr_o, instr_pc_o, address_o);
    end
  endtask

  task automatic test_reset_fill();
    do_reset(1'b1);
    n_vec++;
    if (instr_valid_o !== 1'b0 || address_o !== 29'd0) begin
      n_err++;
      $display("FAIL fill_cycle0: valid=%b addr=%0d, want 0/0", instr_valid_o, address_o);
    end
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      n_vec++;
      if (instr_valid_o !== 1'b1 || instr_o !== cache_word(29'(k - 1)) ||
          instr_pc_o !== 32'(4 * (k - 1)) || address_o !== 29'(k)) begin
        n_err++;
        $display("FAIL fill_seq%0d: valid=%b instr=%h pc=%h addr=%0d, want 1/%h/%h/%0d",
                 k, instr_valid_o, instr_o, instr_pc_o, address_o,
                 cache_word(29'(k - 1)), 32'(4 * (k - 1)), k);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    for (int k = 0; k < 10; k++) next_cycle();
    n_vec++;
    if (address_o !== 29'd4 || instr_valid_o !== 1'b1 || instr_o !== 32'h0000_0093 || instr_pc_o !== 32'h0) begin
      n_err++;
      $display("FAIL full_hold: addr=%0d valid=%b instr=%h pc=%h, want 4/1/00000093/0",
               address_o, instr_valid_o, instr_o, instr_pc_o);
    end
    instr_ready_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      n_vec++;
      if (instr_valid_o !== 1'b1 || instr_o !== cache_word(29'(k)) ||
          instr_pc_o !== 32'(4 * k) || address_o !== 29'(k + 4)) begin
        n_err++;
        $display("FAIL full_drain%0d: valid=%b instr=%h pc=%h addr=%0d, want 1/%h/%h/%0d",
                 k, instr_valid_o, instr_o, instr_pc_o, address_o,
                 cache_word(29'(k)), 32'(4 * k), k + 4);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) next_cycle();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_00A3;
    #1;
    n_vec++;
    if (instr_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL redir_mask: valid=%b, want 0", instr_valid_o);
    end
    @(negedge clk);
    redirect_i    = 1'b0;
    instr_ready_i = 1'b1;
    #1;
    n_vec++;
    if (address_o !== 29'd40 || instr_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL redir_addr: addr=%0d valid=%b, want 40/0", address_o, instr_valid_o);
    end
    next_cycle();
    n_vec++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0000_00A0 || instr_o !== cache_word(29'd40)) begin
      n_err++;
      $display("FAIL redir_target: valid=%b pc=%h instr=%h, want 1/000000a0/%h",
               instr_valid_o, instr_pc_o, instr_o, cache_word(29'd40));
    end
    next_cycle();
    n_vec++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0000_00A4) begin
      n_err++;
      $display("FAIL redir_next: valid=%b pc=%h, want 1/000000a4", instr_valid_o, instr_pc_o);
    end
  endtask

  task automatic test_redirect_pop();
    do_reset(1'b0);
    for (int k = 0; k < 2; k++) next_cycle();
    instr_ready_i = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    #1;
    n_vec++;
    if (instr_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL redpop_nohs: valid=%b, want 0", instr_valid_o);
    end
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    n_vec++;
    if (instr_valid_o !== 1'b0 || address_o !== 29'h40) begin
      n_err++;
      $display("FAIL redpop_empty: valid=%b addr=%h, want 0/40", instr_valid_o, address_o);
    end
    next_cycle();
    n_vec++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0000_0100 || instr_o !== cache_word(29'h40)) begin
      n_err++;
      $display("FAIL redpop_target: valid=%b pc=%h instr=%h, want 1/00000100/%h",
               instr_valid_o, instr_pc_o, instr_o, cache_word(29'h40));
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    next_cycle();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    @(negedge clk);
    redirect_pc_i = 32'h0000_0300;
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    n_vec++;
    if (address_o !== 29'hC0 || instr_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_last_wins: addr=%h valid=%b, want c0/0", address_o, instr_valid_o);
    end
    next_cycle();
    n_vec++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0000_0300) begin
      n_err++;
      $display("FAIL b2b_target: valid=%b pc=%h, want 1/00000300", instr_valid_o, instr_pc_o);
    end
  endtask

  task automatic test_halt();
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) next_cycle();
    halt_i        = 1'b1;
    instr_ready_i = 1'b1;
    #1;
    for (int j = 0; j < 5; j++) begin
      n_vec++;
      if (address_o !== 29'd3) begin
        n_err++;
        $display("FAIL halt_addr%0d: addr=%0d, want 3", j, address_o);
      end
      n_vec++;
      if (j < 3) begin
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'(4 * j) || instr_o !== cache_word(29'(j))) begin
          n_err++;
          $display("FAIL halt_drain%0d: valid=%b pc=%h instr=%h, want 1/%h/%h",
                   j, instr_valid_o, instr_pc_o, instr_o, 32'(4 * j), cache_word(29'(j)));
        end
      end else if (instr_valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL halt_empty%0d: valid=%b, want 0", j, instr_valid_o);
      end
      if (j < 4) next_cycle();
    end
    @(negedge clk);
    halt_i = 1'b0;
    #1;
    for (int k = 3; k <= 4; k++) begin
      next_cycle();
      n_vec++;
      if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'(4 * k) || address_o !== 29'(k + 1)) begin
        n_err++;
        $display("FAIL halt_resume%0d: valid=%b pc=%h addr=%0d, want 1/%h/%0d",
                 k, instr_valid_o, instr_pc_o, address_o, 32'(4 * k), k + 1);
      end
    end
  endtask

  task automatic test_wrap_async_reset();
    do_reset(1'b1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    n_vec++;
    if (address_o !== 29'h1FFF_FFFF) begin
      n_err++;
      $display("FAIL wrap_addr: addr=%h, want 1fffffff", address_o);
    end
    next_cycle();
    n_vec++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'hFFFF_FFFC || address_o !== 29'h0) begin
      n_err++;
      $display("FAIL wrap_last: valid=%b pc=%h addr=%h, want 1/fffffffc/0",
               instr_valid_o, instr_pc_o, address_o);
    end
    next_cycle();
    n_vec++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0 || instr_o !== 32'h0000_0093) begin
      n_err++;
      $display("FAIL wrap_zero: valid=%b pc=%h instr=%h, want 1/0/00000093",
               instr_valid_o, instr_pc_o, instr_o);
    end
    #1;
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if (instr_valid_o !== 1'b0 || instr_o !== 32'h0 || instr_pc_o !== 32'h0 || address_o !== 29'h0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b instr=%h pc=%h addr=%h, want 0/0/0/0",
               instr_valid_o, instr_o, instr_pc_o, address_o);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_reset_fill();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_back_to_back();
    test_halt();
    test_wrap_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
